// File: rtl/lsu_if.sv
// Core-side request/response and memory bus channels of the load/store unit.
// The slave modport is the LSU; the master modport is the core plus memory side.
interface lsu_if #(
   parameter int REG_W = 32
);
   logic             reqValid;
   logic             is_store;
   logic [1:0]       size;
   logic             is_unsigned;
   logic [REG_W-1:0] addr;
   logic [REG_W-1:0] wdata;
   logic             respValid;
   logic [REG_W-1:0] rdata;
   logic             err;
   logic             mem_req_valid;
   logic             mem_req_ready;
   logic             mem_we;
   logic [REG_W-1:0] mem_addr;
   logic [REG_W-1:0] mem_wdata;
   logic [3:0]       mem_wstrb;
   logic             mem_resp_valid;
   logic [REG_W-1:0] mem_rdata;

   modport slave (
      input  reqValid, is_store, size, is_unsigned, addr, wdata,
      output respValid, rdata, err,
      output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );

   modport master (
      output reqValid, is_store, size, is_unsigned, addr, wdata,
      input  respValid, rdata, err,
      input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit: alignment check, byte-lane steering,
// load extension and a WAIT timeout, with registered completion outputs.
module lsu #(
   parameter int TIMEOUT = 255,
   parameter int REG_W   = 32
) (
   input  logic clk,
   input  logic rst_n,
   lsu_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

   state_t           r_state, w_state_next;
   logic [REG_W-1:0] r_addr, r_wdata, r_mem_rdata, r_rdata;
   logic [1:0]       r_size;
   logic             r_is_store, r_is_unsigned, r_err_pend;
   logic [31:0]      r_cnt;
   logic             r_resp_valid, r_err;
   logic             w_req_bad, w_timeout, w_in_req;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [REG_W-1:0] w_load;

   assign w_req_bad = (bus.size == 2'b11)
                    | ((bus.size == 2'b01) & bus.addr[0])
                    | ((bus.size == 2'b10) & (|bus.addr[1:0]));
   // Counter value TIMEOUT-1 marks the TIMEOUT-th WAIT cycle.
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);
   assign w_in_req  = (r_state == S_REQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (bus.reqValid) w_state_next = w_req_bad ? S_DONE : S_REQ;
         S_REQ:  if (bus.mem_req_ready) w_state_next = S_WAIT;
         S_WAIT: if (bus.mem_resp_valid || w_timeout) w_state_next = S_DONE;
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_byte = r_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
      w_half = r_mem_rdata[{r_addr[1], 4'b0000} +: 16];
      w_load = '0;
      if (!r_is_store && !r_err_pend) begin
         case (r_size)
            2'b00:   w_load = r_is_unsigned ? {{(REG_W-8){1'b0}}, w_byte}
                                            : {{(REG_W-8){w_byte[7]}}, w_byte};
            2'b01:   w_load = r_is_unsigned ? {{(REG_W-16){1'b0}}, w_half}
                                            : {{(REG_W-16){w_half[15]}}, w_half};
            default: w_load = r_mem_rdata;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr        <= '0;
         r_wdata       <= '0;
         r_size        <= '0;
         r_is_store    <= 1'b0;
         r_is_unsigned <= 1'b0;
         r_err_pend    <= 1'b0;
         r_mem_rdata   <= '0;
         r_cnt         <= '0;
         r_resp_valid  <= 1'b0;
         r_err         <= 1'b0;
         r_rdata       <= '0;
      end else begin
         r_resp_valid <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: if (bus.reqValid) begin
               r_addr        <= bus.addr;
               r_wdata       <= bus.wdata;
               r_size        <= bus.size;
               r_is_store    <= bus.is_store;
               r_is_unsigned <= bus.is_unsigned;
               r_err_pend    <= w_req_bad;
               r_mem_rdata   <= '0;
            end
            S_REQ: if (bus.mem_req_ready) r_cnt <= '0;
            S_WAIT: begin
               r_cnt <= r_cnt + 32'd1;
               // A response on the timeout cycle still counts as success.
               if (bus.mem_resp_valid) begin
                  r_mem_rdata <= bus.mem_rdata;
                  r_err_pend  <= 1'b0;
               end else if (w_timeout) begin
                  r_err_pend  <= 1'b1;
               end
            end
            S_DONE: begin
               r_err   <= r_err_pend;
               r_rdata <= w_load;
            end
            default: ;
         endcase
      end
   end

   // Bus request fields are zero outside REQ and come only from latched state.
   assign bus.mem_req_valid = w_in_req;
   assign bus.mem_we        = w_in_req & r_is_store;
   assign bus.mem_addr      = w_in_req ? {r_addr[REG_W-1:2], 2'b00} : '0;

   always_comb begin
      bus.mem_wstrb = 4'b0000;
      bus.mem_wdata = '0;
      if (w_in_req) begin
         case (r_size)
            2'b00: begin
               bus.mem_wstrb = 4'b0001 << r_addr[1:0];
               bus.mem_wdata = {(REG_W/8){r_wdata[7:0]}};
            end
            2'b01: begin
               bus.mem_wstrb = 4'b0011 << r_addr[1:0];
               bus.mem_wdata = {(REG_W/16){r_wdata[15:0]}};
            end
            default: begin
               bus.mem_wstrb = 4'b1111;
               bus.mem_wdata = r_wdata;
            end
         endcase
      end
   end

   assign bus.respValid = r_resp_valid;
   assign bus.err       = r_err;
   assign bus.rdata     = r_rdata;
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL take parameter TIMEOUT, default 255: maximum WAIT cycles before the block aborts with an error; 0 disables the timeout.
REQ-002 The block SHALL take parameter REG_W, default 32: data and address width, sourced from reg_defines.

Ports (name  direction  width  meaning):
REQ-003 The block SHALL have port clk  in  1: single clock, rising edge.
REQ-004 The block SHALL have port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port reqValid  in  1: core access request, sampled only in IDLE.
REQ-006 The block SHALL have port is_store  in  1: 1 = store, 0 = load.
REQ-007 The block SHALL have port size  in  2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The block SHALL have port is_unsigned  in  1: zero-extend load data (LBU/LHU).
REQ-009 The block SHALL have port addr  in  32: byte address (the execute stage's lsu_addr).
REQ-010 The block SHALL have port wdata  in  32: store data (the execute stage's lsu_wdata).
REQ-011 The block SHALL have port respValid  out  1: one-cycle completion pulse.
REQ-012 The block SHALL have port rdata  out  32: extended load result, feeds the execute stage's lsu_rdata.
REQ-013 The block SHALL have port err  out  1: misaligned, illegal size or timeout; valid with respValid.
REQ-014 The block SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4: bus request channel.
REQ-015 The block SHALL have ports mem_resp_valid in 1, mem_rdata in 32: bus response channel; loads return data, stores return an acknowledge.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DONE.
REQ-017 IDLE with reqValid=1: latch addr, wdata, size, is_store, is_unsigned.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11 -> DONE with err=1, no bus request.
  - Otherwise -> REQ.
REQ-018 reqValid SHALL be ignored in every state other than IDLE.
REQ-019 REQ: mem_req_valid=1; on mem_req_ready=1 -> WAIT.
REQ-020 mem_we, mem_addr, mem_wdata and mem_wstrb SHALL be driven from the latched values, stable for the whole REQ state.
REQ-021 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-022 mem_wstrb SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-023 mem_wdata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-024 WAIT: mem_resp_valid=1 -> DONE, err=0. A mem_resp_valid seen in REQ or IDLE SHALL be ignored.
REQ-025 Load data extraction SHALL be: byte mem_rdata[8*addr[1:0]+:8]; half mem_rdata[16*addr[1]+:16]; sign-extended unless is_unsigned=1; word passes through.
REQ-026 Stores and errored accesses SHALL complete with rdata=0.
REQ-027 Timeout: a counter SHALL clear on entry to WAIT and increment each WAIT cycle; if TIMEOUT!=0 and the counter reaches TIMEOUT with no response -> DONE, err=1.
REQ-028 If mem_resp_valid arrives on the same cycle the counter reaches TIMEOUT, the response SHALL win (err=0).
REQ-029 DONE: respValid=1 for exactly one cycle, then -> IDLE.
REQ-030 rdata and err SHALL hold their values until the next DONE.
REQ-031 Minimum latency: reqValid accepted at edge N, ready and response both immediate -> respValid high in the cycle after edge N+3.
REQ-032 Misaligned or illegal-size requests SHALL produce respValid in the cycle after edge N+1.
REQ-033 The block SHALL support exactly one outstanding access; a new request SHALL be accepted no earlier than the cycle after DONE.

Reset
REQ-034 While rst_n=0, asynchronously: state=IDLE, respValid=0, err=0, rdata=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, counter=0.
REQ-035 Reset asserted in REQ or WAIT SHALL abandon the access with no respValid.
REQ-036 After reset, a late mem_resp_valid arriving in IDLE SHALL be ignored.

Verification
REQ-037 LB, addr=0x1003, mem_rdata=0x80FF_1234 -> mem_addr=0x1000, rdata=0xFFFF_FF80, err=0; LBU on the same data -> rdata=0x0000_0080.
REQ-038 SH, addr=0x2002, wdata=0x0000_ABCD -> mem_wstrb=4'b1100, mem_wdata=0xABCD_ABCD, mem_we=1; ack -> respValid, rdata=0.
REQ-039 LW, addr=0x3001 -> no mem_req_valid, respValid in the cycle after edge N+1 with err=1; LH, addr=0x3002 -> proceeds normally.
REQ-040 mem_req_ready held low 5 cycles -> request fields constant throughout; a new reqValid pulse during the stall is not accepted.
REQ-041 TIMEOUT=4, no response -> err=1 after 4 WAIT cycles; repeat with mem_resp_valid on the 4th cycle -> err=0 with data returned.
REQ-042 rst_n pulsed low during WAIT -> all outputs zero immediately, no respValid; a stale mem_resp_valid afterwards is ignored.
